aes_out_serializer: RTL and testbench

- Downstream consumer of the pipelined AES-128 core (`top`: 128-bit state/key in, 128-bit out, one block per clock, fixed latency).
- Tracks which core cycles carry real blocks with a tag delay line matched to core latency.
- Captures each valid ciphertext into a small 128-bit FIFO.
- Streams ciphertext out as 32-bit words on a valid/ready interface, most-significant word first.

---
 rtl/aes_out_serializer.sv | 93 +++++++++
 tb/tb_aes_out_serializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_out_serializer.sv
// Output stage of the pipelined AES-128 core. Valid ciphertexts are tagged, queued
// in a small block FIFO and streamed as 32-bit words, most-significant word first.
module aes_out_serializer #(
  parameter  int LATENCY = 21,
  parameter  int DEPTH   = 4,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic [127:0]  aes_out,
  output logic [31:0]   o_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic          o_last,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  logic [LATENCY-1:0] r_sr;
  logic [127:0]       r_mem [DEPTH];
  logic [PW-1:0]      r_wp;
  logic [PW-1:0]      r_rp;
  logic [CW-1:0]      r_count;
  logic [1:0]         r_idx;
  logic               r_ovf;

  logic               w_cap;
  logic               w_hs;
  logic               w_pop;
  logic               w_accept;
  logic [127:0]       w_head;

  // Tag line mirrors the core pipeline so only issued blocks are captured.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= issue;
      for (int i = 1; i < LATENCY; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign w_cap    = r_sr[LATENCY-1];
  assign w_head   = r_mem[r_rp];
  assign o_valid  = (r_count != '0);
  assign w_hs     = o_valid && o_ready;
  assign w_pop    = w_hs && (r_idx == 2'd3);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_accept = w_cap && ((r_count < CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wp] <= aes_out;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) r_wp <= r_wp + 1'b1;
      if (w_pop)    r_rp <= r_rp + 1'b1;
      if (w_hs)     r_idx <= r_idx + 1'b1;
      if (w_cap && !w_accept) r_ovf <= 1'b1;
      unique case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_data = '0;
    if (o_valid) begin
      unique case (r_idx)
        2'd0:    o_data = w_head[127:96];
        2'd1:    o_data = w_head[95:64];
        2'd2:    o_data = w_head[63:32];
        default: o_data = w_head[31:0];
      endcase
    end
  end

  assign o_last     = o_valid && (r_idx == 2'd3);
  assign fifo_count = r_count;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Scoreboard bench for aes_out_serializer: a delay-line core model feeds aes_out,
// expected words are queued at issue time and a monitor checks every handshake.
module tb_aes_out_serializer;
  localparam int LAT = 21;
  localparam int DEP = 4;
  localparam int CW  = $clog2(DEP + 1);

  logic          clk;
  logic          rst;
  logic          issue;
  logic [127:0]  aes_out;
  logic [31:0]   o_data;
  logic          o_valid;
  logic          o_ready;
  logic          o_last;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  aes_out_serializer #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .issue(issue), .aes_out(aes_out),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: ciphertext travels LAT stages; non-issue slots carry junk.
  logic [127:0] ct_in;
  logic [127:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= issue ? ct_in : {$urandom, $urandom, $urandom, $urandom};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign aes_out = pipe[LAT-1];

  logic [31:0] q_data [$];
  logic        q_last [$];
  int n_cmp = 0;
  int n_bad = 0;
  int peak  = 0;

  logic [127:0] blk [6];
  localparam logic [127:0] CT_SINGLE = 128'h3925841d02dc09fbdc118597196a0b32;

  always @(negedge clk) begin
    if (rst && o_valid && o_ready) begin
      n_cmp++;
      if (q_data.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word: got %h last=%b, required no output", o_data, o_last);
      end else begin
        logic [31:0] ed;
        logic        el;
        ed = q_data.pop_front();
        el = q_last.pop_front();
        if (o_data !== ed || o_last !== el) begin
          n_bad++;
          $display("FAIL word: got %h last=%b, required %h last=%b", o_data, o_last, ed, el);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  endtask

  task automatic push_blk(input logic [127:0] ct);
    for (int w = 0; w < 4; w++) begin
      q_data.push_back(ct[127-32*w -: 32]);
      q_last.push_back(w == 3);
    end
  endtask

  task automatic do_issue(input logic [127:0] ct, input bit expect_out);
    issue = 1'b1;
    ct_in = ct;
    if (expect_out) push_blk(ct);
    tick();
    issue = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((q_data.size() != 0 || fifo_count != '0) && n < budget) begin
      tick();
      n++;
    end
    check(name, (q_data.size() == 0 && fifo_count == '0), 1);
  endtask

  task automatic wait_count(input string name, input int target, input int budget);
    int n = 0;
    while (int'(fifo_count) != target && n < budget) begin
      tick();
      n++;
    end
    check(name, fifo_count, target);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int gaps;
    int changes;
    int n;
    logic [31:0] held;
    blk[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    blk[1] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    blk[2] = 128'h0545aad56da2a97c3663d1432a3d1c84;
    blk[3] = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    blk[4] = CT_SINGLE;
    blk[5] = 128'hdeadbeef0123456789abcdeffedcba98;
    rst = 1'b0; issue = 1'b0; o_ready = 1'b0; ct_in = '0;
    tick(); tick();
    rst = 1'b1;
    check("rst_valid", o_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_data", o_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);

    // Single block latency and word order
    o_ready = 1'b1;
    do_issue(CT_SINGLE, 1);
    repeat (LAT - 1) tick();
    check("single_not_yet_valid", o_valid, 0);
    tick();
    check("single_valid_rise", o_valid, 1);
    check("single_first_word", o_data, 32'h3925841d);
    wait_drain("single_drain", 20);
    check("single_count_zero", fifo_count, 0);

    // Burst of five back-to-back blocks
    peak = 0;
    for (int b = 0; b < 5; b++) do_issue(blk[b], 1);
    n = 0;
    while (!o_valid && n < LAT + 5) begin tick(); n++; end
    check("burst_valid_seen", o_valid, 1);
    gaps = 0;
    for (int i = 0; i < 20; i++) begin
      if (!o_valid) gaps++;
      tick();
    end
    check("burst_gaps", gaps, 0);
    wait_drain("burst_drain", 20);
    check("burst_peak", peak, 4);
    check("burst_overflow", overflow, 0);

    // Backpressure
    o_ready = 1'b0;
    for (int b = 0; b < 3; b++) do_issue(blk[b], 1);
    wait_count("bp_fill", 3, LAT + 5);
    held = o_data;
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      if (o_data !== held || !o_valid) changes++;
      tick();
    end
    check("bp_hold_stable", changes, 0);
    check("bp_first_word", o_data, 32'h69c4e0d8);
    check("bp_valid", o_valid, 1);
    check("bp_count", fifo_count, 3);
    o_ready = 1'b1;
    wait_drain("bp_drain", 30);

    // Overflow
    o_ready = 1'b0;
    for (int b = 0; b < 6; b++) do_issue(blk[b], b < 4);
    repeat (LAT - 2) tick();
    check("ovf_before_5th", overflow, 0);
    tick();
    check("ovf_at_5th", overflow, 1);
    check("ovf_count", fifo_count, 4);
    tick(); tick();
    o_ready = 1'b1;
    wait_drain("ovf_drain", 40);
    check("ovf_sticky", overflow, 1);
    do_reset();
    check("ovf_cleared_by_reset", overflow, 0);

    // Full FIFO with capture coinciding with the head's final-word pop
    o_ready = 1'b0;
    for (int b = 0; b < 4; b++) do_issue(blk[b], 1);
    wait_count("fp_fill", 4, LAT + 5);
    do_issue(blk[4], 1);
    repeat (LAT - 4) tick();
    o_ready = 1'b1;
    repeat (4) tick();
    check("fp_count", fifo_count, 4);
    check("fp_overflow", overflow, 0);
    wait_drain("fp_drain", 40);

    // Reset with blocks stored and in flight; none of them may appear
    o_ready = 1'b0;
    do_issue(blk[0], 0);
    do_issue(blk[1], 0);
    wait_count("rm_fill", 2, LAT + 5);
    do_issue(blk[2], 0);
    do_issue(blk[3], 0);
    tick(); tick(); tick();
    rst = 1'b0;
    issue = 1'b1;
    ct_in = blk[5];
    tick();
    rst = 1'b1;
    issue = 1'b0;
    check("rm_valid", o_valid, 0);
    check("rm_count", fifo_count, 0);
    check("rm_overflow", overflow, 0);
    check("rm_data", o_data, 0);
    o_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 2 * LAT + 10; i++) begin
      if (o_valid) n++;
      tick();
    end
    check("rm_no_stale_output", n, 0);
    do_issue(CT_SINGLE, 1);
    wait_drain("rm_after_reset_drain", LAT + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
